// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Register indices are stored zero-extended to TAG_AW bits, so REG_AW may not exceed TAG_AW.
package pipe_pkg;

   localparam int unsigned TAG_AW = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      LOADUSE = 2'b01,
      BUSY    = 2'b10,
      FLUSH   = 2'b11
   } hz_state;

   typedef struct packed {
      logic              valid;
      logic [TAG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } stage_tag;

   typedef struct packed {
      stage_tag          tag;
      logic [TAG_AW-1:0] rs1;
      logic [TAG_AW-1:0] rs2;
      logic              use_rs1;
      logic              use_rs2;
   } ex_tag;

   localparam stage_tag TAG_BUBBLE = '0;
   localparam ex_tag    EX_BUBBLE  = '0;

   // A stage is a forwarding source only if it really writes a non-x0 register.
   function automatic logic tag_writes(input stage_tag t);
      return t.valid & t.regwrite & (t.rd != {TAG_AW{1'b0}});
   endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding-source comparator for one EX operand; a MEM hit wins over a WB hit.
module pipe_fwd_sel
   import pipe_pkg::*;
(
   input  stage_tag          mem_tag_i,
   input  stage_tag          wb_tag_i,
   input  logic [TAG_AW-1:0] ex_rs_i,
   input  logic              ex_use_i,
   output fwd_sel            sel_o
);

   logic mem_hit_s;
   logic wb_hit_s;
   logic unused_memread_s;

   assign mem_hit_s        = tag_writes(mem_tag_i) & (mem_tag_i.rd == ex_rs_i) & ex_use_i;
   assign wb_hit_s         = tag_writes(wb_tag_i) & (wb_tag_i.rd == ex_rs_i) & ex_use_i;
   assign unused_memread_s = mem_tag_i.memread ^ wb_tag_i.memread;

   always_comb begin
      if (mem_hit_s) begin
         sel_o = FWD_MEM;
      end else if (wb_hit_s) begin
         sel_o = FWD_WB;
      end else begin
         sel_o = FWD_RF;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller with EX/MEM/WB shadow tags.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned FLUSH_DEPTH = 3,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_busy,
   input  logic              mem_branch_taken,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              ex_kill,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   ex_tag    ex_q, ex_d, id_tag_s;
   stage_tag mem_q, mem_d, wb_q, wb_d;
   hz_state  state_q, state_d;
   fwd_sel   fwd_a_s, fwd_b_s;
   logic     loaduse_s;

   always_comb begin
      id_tag_s              = EX_BUBBLE;
      id_tag_s.tag.valid    = id_valid;
      id_tag_s.tag.rd       = TAG_AW'(id_rd);
      id_tag_s.tag.regwrite = id_regwrite;
      id_tag_s.tag.memread  = id_memread;
      id_tag_s.rs1          = TAG_AW'(id_rs1);
      id_tag_s.rs2          = TAG_AW'(id_rs2);
      id_tag_s.use_rs1      = id_use_rs1;
      id_tag_s.use_rs2      = id_use_rs2;
   end

   assign loaduse_s = id_valid & ex_q.tag.valid & ex_q.tag.memread
                    & (ex_q.tag.rd != {TAG_AW{1'b0}})
                    & (((ex_q.tag.rd == TAG_AW'(id_rs1)) & id_use_rs1)
                     | ((ex_q.tag.rd == TAG_AW'(id_rs2)) & id_use_rs2));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // state_d is the mode in force this cycle; state_q keeps FLUSH and LOADUSE to a single cycle.
   always_comb begin
      state_d = RUN;
      if (!reset) begin
         state_d = RUN;
      end else if (mem_branch_taken && (state_q != FLUSH)) begin
         state_d = FLUSH;
      end else if (ex_busy) begin
         state_d = BUSY;
      end else if (loaduse_s && (state_q != LOADUSE)) begin
         state_d = LOADUSE;
      end else begin
         state_d = RUN;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      ex_kill     = 1'b0;
      case (state_d)
         LOADUSE: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         BUSY: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         FLUSH: begin
            ifid_flush  = (FLUSH_DEPTH >= 32'd1);
            idex_flush  = (FLUSH_DEPTH >= 32'd2);
            exmem_flush = (FLUSH_DEPTH >= 32'd3);
            ex_kill     = ex_busy;
         end
         default: begin
            pc_write = 1'b1;
         end
      endcase
   end

   // A killed multi-cycle op is dropped from EX and never reaches MEM.
   always_comb begin
      wb_d  = mem_q;
      mem_d = ex_q.tag;
      ex_d  = id_tag_s;
      case (state_d)
         LOADUSE: begin
            ex_d = EX_BUBBLE;
         end
         BUSY: begin
            mem_d = TAG_BUBBLE;
            ex_d  = ex_q;
         end
         FLUSH: begin
            mem_d = ((FLUSH_DEPTH >= 32'd3) || ex_busy) ? TAG_BUBBLE : ex_q.tag;
            ex_d  = ((FLUSH_DEPTH >= 32'd2) || ex_busy) ? EX_BUBBLE : id_tag_s;
         end
         default: begin
            ex_d = id_tag_s;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_q  <= EX_BUBBLE;
         mem_q <= TAG_BUBBLE;
         wb_q  <= TAG_BUBBLE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   pipe_fwd_sel u_fwd_a (
      .mem_tag_i (mem_q),
      .wb_tag_i  (wb_q),
      .ex_rs_i   (ex_q.rs1),
      .ex_use_i  (ex_q.use_rs1),
      .sel_o     (fwd_a_s)
   );

   pipe_fwd_sel u_fwd_b (
      .mem_tag_i (mem_q),
      .wb_tag_i  (wb_q),
      .ex_rs_i   (ex_q.rs2),
      .ex_use_i  (ex_q.use_rs2),
      .sel_o     (fwd_b_s)
   );

   assign forward_a = fwd_a_s;
   assign forward_b = fwd_b_s;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((state_d == LOADUSE) || (state_d == BUSY)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
         if (state_d == FLUSH) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end else begin
            flush_cnt_q <= flush_cnt_q;
         end
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed program snippets plus random traffic
// against an instruction-level reference model of the shadow pipeline.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW      = 5;
   localparam int FLUSH_DEPTH = 3;
   localparam int CNT_W       = 32;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam int M_RUN = 0, M_LU = 1, M_BUSY = 2, M_FL = 3;

   logic              clock = 1'b0;
   logic              reset;
   logic              id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic              ex_busy, mem_branch_taken;
   logic              pc_write, ifid_write, idex_bubble;
   logic              ifid_flush, idex_flush, exmem_flush, ex_kill;
   logic [1:0]        forward_a, forward_b;
   logic [CNT_W-1:0]  stall_count, flush_count;

   always #5 clock = ~clock;

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_busy(ex_busy), .mem_branch_taken(mem_branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .ex_kill(ex_kill), .forward_a(forward_a), .forward_b(forward_b),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   typedef struct {
      bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2;
   } ins_t;

   typedef struct {
      bit pcw; bit ifw; bit bub; bit f1; bit f2; bit f3; bit kill;
      int fa; int fb; int unsigned sc; int unsigned fc;
   } exp_t;

   exp_t        exp_q[$];
   ins_t        m_ex, m_mem, m_wb;
   int          m_prev;
   int unsigned m_sc, m_fc;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic ins_t nop();
      ins_t i;
      i = '{default: 0};
      return i;
   endfunction

   function automatic ins_t mk(input int rd, input bit rw, input bit mr,
                               input int rs1, input bit u1, input int rs2, input bit u2);
      ins_t i;
      i = '{v: 1'b1, rd: rd, rw: rw, mr: mr, rs1: rs1, rs2: rs2, u1: u1, u2: u2};
      return i;
   endfunction

   function automatic bit writes(input ins_t s, input int r);
      return s.v && s.rw && (s.rd != 0) && (s.rd == r);
   endfunction

   function automatic int fwd(input int rs, input bit used);
      if (used && writes(m_mem, rs)) return 2;
      if (used && writes(m_wb, rs))  return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_ex = nop(); m_mem = nop(); m_wb = nop();
      m_prev = M_RUN; m_sc = 0; m_fc = 0;
   endtask

   // Drive one cycle of ID/control inputs, queue the expected response, advance the model.
   task automatic step(input ins_t id, input bit busy, input bit br);
      exp_t e;
      int   mode;
      bit   lu;
      id_valid = id.v; id_rd = id.rd[REG_AW-1:0]; id_regwrite = id.rw; id_memread = id.mr;
      id_rs1 = id.rs1[REG_AW-1:0]; id_rs2 = id.rs2[REG_AW-1:0];
      id_use_rs1 = id.u1; id_use_rs2 = id.u2;
      ex_busy = busy; mem_branch_taken = br;
      lu = id.v && m_ex.v && m_ex.mr && (m_ex.rd != 0) &&
           ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
      if (br && m_prev != M_FL)      mode = M_FL;
      else if (busy)                 mode = M_BUSY;
      else if (lu && m_prev != M_LU) mode = M_LU;
      else                           mode = M_RUN;
      e.pcw  = (mode == M_RUN) || (mode == M_FL);
      e.ifw  = e.pcw;
      e.bub  = (mode == M_LU);
      e.f1   = (mode == M_FL) && (FLUSH_DEPTH >= 1);
      e.f2   = (mode == M_FL) && (FLUSH_DEPTH >= 2);
      e.f3   = (mode == M_FL) && (FLUSH_DEPTH >= 3);
      e.kill = (mode == M_FL) && busy;
      e.fa   = fwd(m_ex.rs1, m_ex.u1);
      e.fb   = fwd(m_ex.rs2, m_ex.u2);
      e.sc   = PERF ? m_sc : 0;
      e.fc   = PERF ? m_fc : 0;
      exp_q.push_back(e);
      if (mode == M_LU || mode == M_BUSY) m_sc++;
      if (mode == M_FL) m_fc++;
      m_wb = m_mem;
      case (mode)
         M_RUN:  begin m_mem = m_ex; m_ex = id; end
         M_LU:   begin m_mem = m_ex; m_ex = nop(); end
         M_BUSY: begin m_mem = nop(); end
         default: begin
            m_mem = (FLUSH_DEPTH >= 3 || busy) ? nop() : m_ex;
            m_ex  = (FLUSH_DEPTH >= 2 || busy) ? nop() : id;
         end
      endcase
      m_prev = mode;
      @(posedge clock); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pc_write"}, pc_write, 1'b1);
      chk({tag, "_ifid_write"}, ifid_write, 1'b1);
      chk({tag, "_stall_flush_bits"},
          {idex_bubble, ifid_flush, idex_flush, exmem_flush, ex_kill}, 5'b0);
      chk({tag, "_forward"}, {forward_a, forward_b}, 4'b0);
      chk({tag, "_counters"}, {stall_count, flush_count}, 64'd0);
   endtask

   // Monitor: every cycle's outputs are compared with the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_write", pc_write, e.pcw);
            chk("ifid_write", ifid_write, e.ifw);
            chk("idex_bubble", idex_bubble, e.bub);
            chk("ifid_flush", ifid_flush, e.f1);
            chk("idex_flush", idex_flush, e.f2);
            chk("exmem_flush", exmem_flush, e.f3);
            chk("ex_kill", ex_kill, e.kill);
            chk("forward_a", forward_a, e.fa);
            chk("forward_b", forward_b, e.fb);
            chk("stall_count", stall_count, e.sc);
            chk("flush_count", flush_count, e.fc);
         end
      end
   end

   initial begin
      ins_t r;
      reset = 1'b0;
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
      ex_busy = 1'b0; mem_branch_taken = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_reset_vals("reset");
      reset = 1'b1;

      // ex_busy for four cycles
      repeat (4) step(nop(), 1'b1, 1'b0);
      step(nop(), 1'b0, 1'b0);
      chk("busy_stall_count", stall_count, PERF ? 32'd4 : 32'd0);

      // taken branch while busy: kill, no BUSY
      step(nop(), 1'b1, 1'b1);
      step(nop(), 1'b0, 1'b0);
      chk("flush_count_one", flush_count, PERF ? 32'd1 : 32'd0);

      // add x3,x1,x2 ; sub x4,x3,x5
      step(mk(3, 1, 0, 1, 1, 2, 1), 1'b0, 1'b0);
      step(mk(4, 1, 0, 3, 1, 5, 1), 1'b0, 1'b0);
      chk("alu_fwd_mem", forward_a, 2'b10);
      chk("alu_fwd_mem_b", forward_b, 2'b00);

      // add x3 ; independent ; sub x4,x3,x5
      step(mk(3, 1, 0, 1, 1, 2, 1), 1'b0, 1'b0);
      step(mk(9, 1, 0, 10, 1, 11, 1), 1'b0, 1'b0);
      step(mk(4, 1, 0, 3, 1, 5, 1), 1'b0, 1'b0);
      chk("alu_fwd_wb", forward_a, 2'b01);

      // ld x6,0(x2) ; add x7,x6,x1 (held in ID across the stall)
      step(mk(6, 1, 1, 2, 1, 0, 0), 1'b0, 1'b0);
      step(mk(7, 1, 0, 6, 1, 1, 1), 1'b0, 1'b0);
      step(mk(7, 1, 0, 6, 1, 1, 1), 1'b0, 1'b0);
      chk("loaduse_fwd_wb", forward_a, 2'b01);

      // add x0,x1,x2 ; add x5,x0,x0
      step(mk(0, 1, 0, 1, 1, 2, 1), 1'b0, 1'b0);
      step(mk(5, 1, 0, 0, 1, 0, 1), 1'b0, 1'b0);
      chk("x0_no_fwd", {forward_a, forward_b}, 4'b0000);
      step(mk(0, 1, 1, 2, 1, 0, 0), 1'b0, 1'b0);
      step(mk(8, 1, 0, 0, 1, 0, 1), 1'b0, 1'b0);

      // randomized traffic over a small register window
      for (int i = 0; i < 600; i++) begin
         r.v  = ($urandom_range(0, 9) < 8);
         r.rd = $urandom_range(0, 3);
         r.rw = ($urandom_range(0, 3) != 0);
         r.mr = ($urandom_range(0, 2) == 0);
         r.rs1 = $urandom_range(0, 3);
         r.rs2 = $urandom_range(0, 3);
         r.u1 = ($urandom_range(0, 4) != 0);
         r.u2 = ($urandom_range(0, 1) != 0);
         step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      end

      // asynchronous reset in the middle of a BUSY stall
      step(nop(), 1'b1, 1'b0);
      step(nop(), 1'b1, 1'b0);
      #1;
      chk("busy_before_reset", pc_write, 1'b0);
      reset = 1'b0;
      #1;
      check_reset_vals("async_reset");
      @(posedge clock); #1;
      ex_busy = 1'b0;
      model_reset();
      reset = 1'b1;
      step(mk(3, 1, 0, 1, 1, 2, 1), 1'b0, 1'b0);
      step(mk(4, 1, 0, 3, 1, 3, 1), 1'b0, 1'b0);
      step(nop(), 1'b0, 1'b0);

      @(negedge clock); #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
